// File: rtl/lc3_memaccess_seq.sv
// LC-3 MemAccess sequencer: one load/store at a time, with LDI/STI performing a
// pointer fetch followed by the real access, absorbing MEM_LAT cycles of read latency.
module lc3_memaccess_seq #(
  parameter int MEM_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_data,
  output logic        DMem_en,
  output logic        DMem_rd,
  output logic [15:0] DMem_addr,
  output logic [15:0] Dmem_din,
  input  logic [15:0] DMem_dout,
  output logic [15:0] memout,
  output logic        done
);

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_STI = 2'b11;
  localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, DONE
  } state_t;

  state_t      state_reg;
  logic [1:0]  op_reg;
  logic [15:0] data_reg;
  logic [2:0]  cnt_reg;

  // Outputs are registered: each is loaded on the transition into the state that presents it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      op_reg    <= OP_LD;
      data_reg  <= '0;
      cnt_reg   <= '0;
      req_ready <= 1'b1;
      DMem_en   <= 1'b0;
      DMem_rd   <= 1'b1;
      DMem_addr <= '0;
      Dmem_din  <= '0;
      memout    <= '0;
      done      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            op_reg    <= req_op;
            data_reg  <= req_data;
            state_reg <= ISSUE1;
            req_ready <= 1'b0;
            DMem_en   <= 1'b1;
            DMem_addr <= req_addr;
            if (req_op == OP_ST) begin
              DMem_rd  <= 1'b0;
              Dmem_din <= req_data;
            end else begin
              DMem_rd <= 1'b1;
            end
          end
        end
        ISSUE1: begin
          DMem_en <= 1'b0;
          DMem_rd <= 1'b1;
          if (op_reg == OP_ST) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end else begin
            state_reg <= WAIT1;
            cnt_reg   <= LAT_LAST;
          end
        end
        WAIT1: begin
          if (cnt_reg == 3'd0) begin
            if (op_reg == OP_LD) begin
              memout    <= DMem_dout;
              state_reg <= DONE;
              done      <= 1'b1;
            end else begin
              // Pointer goes straight onto the address bus for the second access.
              state_reg <= ISSUE2;
              DMem_en   <= 1'b1;
              DMem_addr <= DMem_dout;
              if (op_reg == OP_STI) begin
                DMem_rd  <= 1'b0;
                Dmem_din <= data_reg;
              end else begin
                DMem_rd <= 1'b1;
              end
            end
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        ISSUE2: begin
          DMem_en <= 1'b0;
          DMem_rd <= 1'b1;
          if (op_reg == OP_STI) begin
            state_reg <= DONE;
            done      <= 1'b1;
          end else begin
            state_reg <= WAIT2;
            cnt_reg   <= LAT_LAST;
          end
        end
        WAIT2: begin
          if (cnt_reg == 3'd0) begin
            memout    <= DMem_dout;
            state_reg <= DONE;
            done      <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 3'd1;
          end
        end
        DONE: begin
          done      <= 1'b0;
          req_ready <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          req_ready <= 1'b1;
          DMem_en   <= 1'b0;
          DMem_rd   <= 1'b1;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_memaccess_seq.sv
// Randomised bench for lc3_memaccess_seq: a latency-accurate memory responder plus a
// transaction-level model predicting strobes, completion time and memout per request.
module tb_lc3_memaccess_seq;

  localparam int L = 2;
  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_STI = 2'b11;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic        DMem_en;
  logic        DMem_rd;
  logic [15:0] DMem_addr;
  logic [15:0] Dmem_din;
  logic [15:0] DMem_dout;
  logic [15:0] memout;
  logic        done;

  lc3_memaccess_seq #(.MEM_LAT(L)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .DMem_en(DMem_en), .DMem_rd(DMem_rd), .DMem_addr(DMem_addr),
    .Dmem_din(Dmem_din), .DMem_dout(DMem_dout),
    .memout(memout), .done(done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int txn = 0;
  logic [15:0] exp_memout = 16'h0;
  logic [15:0] exp_din = 16'h0;

  logic [15:0] mem [0:65535];
  logic        rv [0:7];
  logic [15:0] ra [0:7];

  always @(posedge clock) cyc++;

  // Memory: read data appears exactly L cycles after a read strobe, junk otherwise.
  always @(negedge clock) begin
    int k;
    rv[cyc % 8] = DMem_en && DMem_rd && !reset;
    ra[cyc % 8] = DMem_addr;
    if (DMem_en && !DMem_rd && !reset) mem[DMem_addr] = Dmem_din;
    k = (cyc + 8 - L) % 8;
    DMem_dout = rv[k] ? mem[ra[k]] : 16'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (txn %0d)", tag, got, exp, txn);
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_ready"}, 32'(req_ready), 32'd1);
    check({pfx, "_en"}, 32'(DMem_en), 32'd0);
    check({pfx, "_rd"}, 32'(DMem_rd), 32'd1);
    check({pfx, "_addr"}, 32'(DMem_addr), 32'd0);
    check({pfx, "_din"}, 32'(Dmem_din), 32'd0);
    check({pfx, "_memout"}, 32'(memout), 32'd0);
    check({pfx, "_done"}, 32'(done), 32'd0);
  endtask

  // Issue one request (called at a negedge) and check it against the model.
  task automatic run_req(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                         input bit keep, input bit b2b);
    int n_exp, n_obs, done_off, exp_done, t;
    int e_off [2];
    logic e_rd [2];
    logic [15:0] e_addr [2];
    int o_off [4];
    logic o_rd [4];
    logic [15:0] o_addr [4];
    logic [15:0] o_din [4];
    logic [15:0] p, last_addr, new_memout, new_din;
    bit got_done;

    p = mem[a];
    new_memout = exp_memout;
    new_din = exp_din;
    e_off[0] = 1; e_rd[0] = 1'b1; e_addr[0] = a;
    e_off[1] = 2 + L; e_rd[1] = 1'b1; e_addr[1] = p;
    case (op)
      OP_LD:  begin n_exp = 1; exp_done = 2 + L; new_memout = mem[a]; last_addr = a; end
      OP_LDI: begin n_exp = 2; exp_done = 3 + 2 * L; new_memout = mem[p]; last_addr = p; end
      OP_ST:  begin n_exp = 1; e_rd[0] = 1'b0; exp_done = 2; new_din = d; last_addr = a; end
      default: begin n_exp = 2; e_rd[1] = 1'b0; exp_done = 3 + L; new_din = d; last_addr = p; end
    endcase

    req_op = op; req_addr = a; req_data = d; req_valid = 1'b1;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clock);
    if (!req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      return;
    end
    t = cyc;
    if (b2b) check("reaccept_cycle", 32'(t - last_done_cyc), 32'd1);

    n_obs = 0;
    done_off = -1;
    got_done = 1'b0;
    for (int i = 1; i <= 24 && !got_done; i++) begin
      @(negedge clock);
      if (i == 1) begin
        req_op = 2'($urandom); req_addr = 16'($urandom); req_data = 16'($urandom);
        if (!keep) req_valid = 1'b0;
      end
      if (DMem_en) begin
        if (n_obs < 4) begin
          o_off[n_obs] = cyc - t; o_rd[n_obs] = DMem_rd;
          o_addr[n_obs] = DMem_addr; o_din[n_obs] = Dmem_din;
        end
        n_obs++;
      end
      if (done) begin
        got_done = 1'b1;
        done_off = cyc - t;
        check("done_memout", 32'(memout), 32'(new_memout));
        check("done_en_idle", 32'(DMem_en), 32'd0);
        check("done_rd_idle", 32'(DMem_rd), 32'd1);
        check("done_addr_hold", 32'(DMem_addr), 32'(last_addr));
        check("done_din_hold", 32'(Dmem_din), 32'(new_din));
        check("done_ready_low", 32'(req_ready), 32'd0);
      end
    end
    if (!got_done) check("done_timeout", 32'd0, 32'd1);
    check("done_cycle", 32'(done_off), 32'(exp_done));
    check("strobe_count", 32'(n_obs), 32'(n_exp));
    for (int s = 0; s < n_exp && s < n_obs; s++) begin
      check("strobe_cycle", 32'(o_off[s]), 32'(e_off[s]));
      check("strobe_rd", 32'(o_rd[s]), 32'(e_rd[s]));
      check("strobe_addr", 32'(o_addr[s]), 32'(e_addr[s]));
      if (!e_rd[s]) check("strobe_din", 32'(o_din[s]), 32'(d));
    end
    $display("txn %0d op=%0d addr=%h data=%h ptr=%h done_off=%0d memout=%h",
             txn, op, a, d, p, done_off, memout);
    exp_memout = new_memout;
    exp_din = new_din;
    last_done_cyc = cyc;
    txn++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, n_bad_done, n_bad_en;
    logic [15:0] a;
    reset = 1'b1; req_valid = 1'b0; req_op = OP_LD; req_addr = '0; req_data = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) begin rv[i] = 1'b0; ra[i] = '0; end
    mem[16'h3010] = 16'h1234;
    mem[16'h4000] = 16'h5000;
    mem[16'h5000] = 16'hA5A5;
    mem[16'hFFFF] = 16'h0002;
    repeat (3) @(negedge clock);
    check_reset_vals("por");
    reset = 1'b0;
    @(negedge clock);

    run_req(OP_ST,  16'h3000, 16'hBEEF, 1'b0, 1'b0);
    run_req(OP_LD,  16'h3010, 16'h0000, 1'b0, 1'b1);
    run_req(OP_LDI, 16'h4000, 16'h1111, 1'b0, 1'b1);
    run_req(OP_STI, 16'hFFFF, 16'h7777, 1'b0, 1'b1);
    check("sti_mem_written", 32'(mem[16'h0002]), 32'h7777);
    run_req(OP_LD,  16'h0002, 16'h0000, 1'b1, 1'b1);
    run_req(OP_LD,  16'h3000, 16'h0000, 1'b0, 1'b1);

    // LDI aborted by reset in its first WAIT2 cycle.
    req_op = OP_LDI; req_addr = 16'h4000; req_data = '0; req_valid = 1'b1;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clock);
    t = cyc;
    @(negedge clock);
    req_valid = 1'b0;
    while (cyc < t + 3 + L) @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clock);
    reset = 1'b0;
    exp_memout = 16'h0; exp_din = 16'h0;
    n_bad_done = 0; n_bad_en = 0;
    repeat (2 * L + 4) begin
      @(negedge clock);
      if (done) n_bad_done++;
      if (DMem_en) n_bad_en++;
    end
    check("midrst_no_done", 32'(n_bad_done), 32'd0);
    check("midrst_no_strobe", 32'(n_bad_en), 32'd0);
    run_req(OP_LD, 16'h3010, 16'h0000, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: a = 16'hFFFF;
        1: a = 16'h0000;
        default: a = 16'($urandom);
      endcase
      run_req(2'($urandom), a, 16'($urandom), 1'($urandom), 1'b1);
    end

    req_valid = 1'b0;
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
